// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file dump logic.
//   REG_ADDR_W   : register index width (32 architectural registers)
//   XLEN         : register data width
//   dump_state_t : dumper FSM state encoding
package regfile_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int XLEN       = 32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_WAIT,
    ST_SEND,
    ST_DONE
  } dump_state_t;

endpackage

// File: rtl/regfile_dumper.sv
// Walks a range of register indices, reads each one through a registered
// regfile read port, and streams (index, value) pairs out over a
// valid/ready handshake.
//   clk, reset            : clock, asynchronous active-high reset
//   start, abort          : begin a dump (sampled in IDLE) / cancel a dump
//   start_addr, end_addr  : inclusive index range, wrapping modulo 32
//   rf_rdAddr, rf_rdData  : regfile read port (data one cycle after address)
//   out_valid/out_ready   : output handshake carrying out_data/out_index
//   busy, done            : FSM not idle / one-cycle completion pulse
module regfile_dumper
  import regfile_pkg::*;
#(
  parameter bit SKIP_X0 = 1'b0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  abort,
  input  logic [REG_ADDR_W-1:0] start_addr,
  input  logic [REG_ADDR_W-1:0] end_addr,
  output logic [REG_ADDR_W-1:0] rf_rdAddr,
  input  logic [XLEN-1:0]       rf_rdData,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [XLEN-1:0]       out_data,
  output logic [REG_ADDR_W-1:0] out_index,
  output logic                  busy,
  output logic                  done
);

  dump_state_t           state;
  logic [REG_ADDR_W-1:0] end_q;
  logic [REG_ADDR_W-1:0] first_addr;
  logic [REG_ADDR_W-1:0] last_addr;
  logic [REG_ADDR_W-1:0] next_addr;
  logic                  empty_range;

  always_comb begin
    first_addr  = start_addr;
    last_addr   = end_addr;
    empty_range = 1'b0;
    if (SKIP_X0) begin
      if (start_addr == '0) first_addr = REG_ADDR_W'(1);
      // With x0 skipped, an end of 0 means "stop after 31"; a range of
      // exactly {0} has nothing left to emit.
      if (end_addr == '0) last_addr = '1;
      empty_range = (start_addr == '0) && (end_addr == '0);
    end
  end

  always_comb begin
    next_addr = out_index + REG_ADDR_W'(1);
    if (SKIP_X0 && next_addr == '0) next_addr = REG_ADDR_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      rf_rdAddr <= '0;
      out_index <= '0;
      out_data  <= '0;
      end_q     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            rf_rdAddr <= first_addr;
            out_index <= first_addr;
            end_q     <= last_addr;
            state     <= empty_range ? ST_DONE : ST_READ;
          end
        end
        ST_READ: begin
          state <= abort ? ST_IDLE : ST_WAIT;
        end
        ST_WAIT: begin
          if (abort) begin
            state <= ST_IDLE;
          end else begin
            out_data <= rf_rdData;
            state    <= ST_SEND;
          end
        end
        ST_SEND: begin
          // abort outranks a handshake completing on the same edge
          if (abort) begin
            state <= ST_IDLE;
          end else if (out_ready) begin
            if (out_index == end_q) begin
              state <= ST_DONE;
            end else begin
              rf_rdAddr <= next_addr;
              out_index <= next_addr;
              state     <= ST_READ;
            end
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign out_valid = (state == ST_SEND);
  assign busy      = (state != ST_IDLE);
  assign done      = (state == ST_DONE);

endmodule

// File: doc/regfile_dumper.md
REGFILE_DUMPER -- requirements
Module: regfile_dumper

Interface
REQ-001 SHALL have parameter: SKIP_X0, default 0, when 1 register x0 is never read or emitted.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port: start  input  1  request a dump; sampled only in IDLE.
REQ-005 SHALL have port: abort  input  1  cancel an in-progress dump.
REQ-006 SHALL have port: start_addr  input  5  first register index, sampled with start.
REQ-007 SHALL have port: end_addr  input  5  last register index, sampled with start.
REQ-008 SHALL have port: rf_rdAddr  output  5  read address to a regfile read port; registered.
REQ-009 SHALL have port: rf_rdData  input  32  regfile read data, valid one cycle after rf_rdAddr is sampled.
REQ-010 SHALL have port: out_valid  output  1  out_data/out_index valid.
REQ-011 SHALL have port: out_ready  input  1  downstream accepts word.
REQ-012 SHALL have port: out_data  output  32  register value.
REQ-013 SHALL have port: out_index  output  5  register index of out_data.
REQ-014 SHALL have port: busy  output  1  high in every state except IDLE.
REQ-015 SHALL have port: done  output  1  one-cycle pulse after last word accepted.

Function
REQ-016 SHALL implement FSM states IDLE, READ, WAIT, SEND, DONE.
REQ-017 IDLE: on start=1, SHALL load rf_rdAddr and out_index with start_addr (or start_addr+1 when SKIP_X0=1 and start_addr=0), latch end_addr, go to READ.
REQ-018 READ: SHALL go to WAIT next edge (regfile samples rf_rdAddr).
REQ-019 WAIT: SHALL capture rf_rdData into out_data and go to SEND; out_valid rises the cycle after.
REQ-020 Latency SHALL be exactly 3 edges from start sampled to out_valid=1 (start edge, READ edge, WAIT edge).
REQ-021 SEND: out_valid=1; out_data, out_index, rf_rdAddr SHALL hold stable while out_ready=0.
REQ-022 SEND with out_ready=1: if out_index==latched end, go to DONE; else increment rf_rdAddr/out_index modulo 32 and go to READ.
REQ-023 Increment SHALL wrap 31->0; with SKIP_X0=1, 31 SHALL wrap to 1 and 0 SHALL be skipped.
REQ-024 start_addr==end_addr SHALL emit exactly one word; end_addr==start_addr-1 mod 32 SHALL emit 32 words (31 with SKIP_X0=1).
REQ-025 SKIP_X0=1 with start_addr=end_addr=0 SHALL emit no words: IDLE -> DONE directly.
REQ-026 SKIP_X0=1 with end_addr=0 and start_addr!=0 SHALL terminate after emitting index 31.
REQ-027 DONE: done=1 for exactly one cycle, then IDLE.
REQ-028 start while busy=1 SHALL be ignored.
REQ-029 abort=1 in any non-IDLE state SHALL go to IDLE next edge, out_valid=0, no done pulse; abort has priority over handshake completion in the same cycle.
REQ-030 abort and start together in IDLE: start SHALL win (abort ignored in IDLE).
REQ-031 Concurrent regfile writes SHALL not be blocked; each word reflects the regfile content at its READ edge (no snapshot guarantee).
REQ-032 out_valid SHALL never depend combinationally on out_ready.

Reset
REQ-033 reset SHALL force IDLE asynchronously, regardless of clock.
REQ-034 Reset values: rf_rdAddr=0, out_index=0, out_data=0, out_valid=0, busy=0, done=0.
REQ-035 Reset mid-dump SHALL discard progress; first start after reset behaves per REQ-017.

Structure
REQ-036 Shared package regfile_pkg SHALL hold REG_ADDR_W=5, XLEN=32 and the dumper state enum.
REQ-037 Single module, no sub-module; FSM and datapath registers coexist in one block.

Verification
REQ-038 Regs preloaded x_i=0xA5A50000+i, start_addr=3, end_addr=5, out_ready=1 -> words (3,0xA5A50003),(4,..04),(5,..05), out_valid first high 3 edges after start, done one pulse.
REQ-039 start_addr=30, end_addr=1, SKIP_X0=0 -> indices 30,31,0,1; x0 value 0x00000000; with SKIP_X0=1 -> 30,31,1.
REQ-040 start_addr=0, end_addr=31, out_ready toggling 1-0-0-1 randomly -> 32 words in order, each held stable while stalled, no duplicates or drops.
REQ-041 abort asserted in SEND with out_ready=1 during index 7 of 4..10 -> index 7 not counted complete, IDLE next edge, done never pulses; new start then works.
REQ-042 Reset asserted asynchronously mid-WAIT -> all outputs to reset values immediately; start ignored while busy verified by second start pulse in SEND producing no restart.
